// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// It launches one frame at a time, watches busy/done, enforces an inter-frame gap and flags start timeouts.
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 1,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_en,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 timeout_err,
    output logic [7:0]           err_count,
    output logic [15:0]          frame_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);
    localparam logic [3:0] TO_LAST  = 4'(START_TIMEOUT - 1);
    // A zero gap still spends one cycle in GAP, so grants are never back-to-back.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [3:0]           to_cnt_q, to_cnt_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_en_q, tx_en_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic                 active_q, active_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic                 hi_found, lo_found;
    logic [2:0]           hi_idx, lo_idx, sel_idx;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [7:0]           sel_data;
    logic                 grant, timeout_hit, frame_done;

    // Lowest valid index at/above the pointer wins; otherwise the lowest valid index overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = 3'd0;
        lo_found = 1'b0;
        lo_idx   = 3'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_found = 1'b1;
                lo_idx   = 3'(j);
                if (j >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(j);
                end
            end
        end
    end

    assign sel_idx = hi_found ? hi_idx : lo_idx;

    always_comb begin
        sel_onehot = '0;
        sel_data   = 8'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == sel_idx) begin
                sel_onehot[j] = 1'b1;
                sel_data      = req_data[j*8 +: 8];
            end
        end
    end

    assign grant       = (state_q == S_IDLE) && en && lo_found;
    assign timeout_hit = (state_q == S_WAIT_BUSY) && !tx_done && !tx_busy && (to_cnt_q == TO_LAST);
    assign frame_done  = tx_done && ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= 3'd0;
            to_cnt_q      <= 4'd0;
            gap_cnt_q     <= 4'd0;
            req_ready_q   <= '0;
            tx_en_q       <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'd0;
            grant_id_q    <= 3'd0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            err_count_q   <= 8'd0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            req_ready_q   <= req_ready_d;
            tx_en_q       <= tx_en_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Counters default to zero, so they are cleared on every state entry.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = 4'd0;
        gap_cnt_d = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_done)                  state_d = S_GAP;
                else if (tx_busy)             state_d = S_WAIT_DONE;
                else if (to_cnt_q == TO_LAST) state_d = S_GAP;
                else                          to_cnt_d = to_cnt_q + 4'd1;
            end
            S_WAIT_DONE: begin
                if (tx_done) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
                else                       gap_cnt_d = gap_cnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d   = '0;
        tx_en_d       = en;
        tx_start_d    = (state_q == S_LAUNCH);
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        active_d      = (state_d != S_IDLE);
        timeout_err_d = timeout_hit;
        err_count_d   = err_count_q;
        frame_count_d = frame_count_q;
        if (grant) begin
            req_ready_d = sel_onehot;
            tx_data_d   = sel_data;
            grant_id_d  = sel_idx;
            ptr_d       = (sel_idx == LAST_IDX) ? 3'd0 : sel_idx + 3'd1;
        end
        if (timeout_hit && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        if (frame_done) frame_count_d = frame_count_q + 16'd1;
    end

    assign req_ready   = req_ready_q;
    assign tx_en       = tx_en_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;
    assign err_count   = err_count_q;
    assign frame_count = frame_count_q;

endmodule
